// File: rtl/sprite_scheduler_if.sv
// Beam position, sprite position and renderer control/pixel signals for sprite_scheduler.
// The master drives beam/position/gfx; the slave (scheduler) returns pulses and the gated pixel.
interface sprite_scheduler_if;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       display_on;
    logic [8:0] sprite_x;
    logic [8:0] sprite_y;
    logic       pos_we;
    logic       gfx;
    logic       inloop;
    logic       vstart;
    logic       load;
    logic       hstart;
    logic       sprite_pixel;
    logic       active;

    modport master (
        output hpos, vpos, display_on, sprite_x, sprite_y, pos_we, gfx, inloop,
        input  vstart, load, hstart, sprite_pixel, active
    );

    modport slave (
        input  hpos, vpos, display_on, sprite_x, sprite_y, pos_we, gfx, inloop,
        output vstart, load, hstart, sprite_pixel, active
    );
endinterface

// File: rtl/sprite_scheduler.sv
// Times vstart/load/hstart for one 16x16 sprite from the beam position and gates its pixel.
// All outputs registered (1 cycle after the sampled beam position); no backpressure, beam-paced.
module sprite_scheduler #(
    parameter int H_DISPLAY = 256,
    parameter int V_DISPLAY = 240,
    parameter int SPRITE_W  = 16,
    parameter int SPRITE_H  = 16,
    parameter int MIN_X     = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    sprite_scheduler_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ARMED    = 3'd1;
    localparam logic [2:0] S_ROW_LOAD = 3'd2;
    localparam logic [2:0] S_ROW_WAIT = 3'd3;
    localparam logic [2:0] S_ROW_DRAW = 3'd4;
    localparam logic [2:0] S_ROW_NEXT = 3'd5;

    localparam logic [8:0] X_MIN    = 9'(MIN_X);
    localparam logic [8:0] X_MAX    = 9'(H_DISPLAY - SPRITE_W);
    localparam logic [8:0] Y_MAX    = 9'(V_DISPLAY - SPRITE_H);
    localparam logic [8:0] Y_OFF    = 9'(V_DISPLAY);
    localparam logic [3:0] ROW_LAST = 4'(SPRITE_H - 1);
    localparam logic [3:0] COL_LAST = 4'(SPRITE_W - 1);

    logic [2:0] state, state_nxt;
    logic [3:0] row, row_nxt;
    logic [3:0] col, col_nxt;
    logic [8:0] shadow_x, shadow_y, lat_x, lat_y, clamp_x;
    logic       vstart_nxt, load_nxt, hstart_nxt;
    logic       vstart_q, load_q, hstart_q, pixel_q, active_q;
    logic       frame_start, window;
    logic       unused_inloop;

    assign unused_inloop = bus.inloop;
    assign frame_start   = (bus.hpos == 9'd0) && (bus.vpos == 9'd0);
    assign window        = (state == S_ROW_DRAW) && !frame_start;

    always_comb begin
        clamp_x = bus.sprite_x;
        if (bus.sprite_x < X_MIN)
            clamp_x = X_MIN;
        else if (bus.sprite_x > X_MAX)
            clamp_x = X_MAX;
    end

    always_comb begin
        state_nxt  = state;
        row_nxt    = row;
        col_nxt    = col;
        vstart_nxt = 1'b0;
        load_nxt   = 1'b0;
        hstart_nxt = 1'b0;
        // Frame start overrides any state, so a too-short vertical total aborts silently.
        if (frame_start) begin
            state_nxt = (shadow_y <= Y_MAX) ? S_ARMED : S_IDLE;
        end else begin
            case (state)
                S_ARMED: if (bus.hpos == 9'd0 && bus.vpos == lat_y) begin
                    vstart_nxt = 1'b1;
                    row_nxt    = 4'd0;
                    state_nxt  = S_ROW_LOAD;
                end
                S_ROW_LOAD: if (bus.hpos == 9'd1) begin
                    load_nxt  = 1'b1;
                    state_nxt = S_ROW_WAIT;
                end
                S_ROW_WAIT: if (bus.hpos == lat_x) begin
                    hstart_nxt = 1'b1;
                    col_nxt    = 4'd0;
                    state_nxt  = S_ROW_DRAW;
                end
                S_ROW_DRAW: begin
                    col_nxt = col + 4'd1;
                    if (col == COL_LAST) begin
                        if (row == ROW_LAST) begin
                            state_nxt = S_IDLE;
                        end else begin
                            row_nxt   = row + 4'd1;
                            state_nxt = S_ROW_NEXT;
                        end
                    end
                end
                S_ROW_NEXT: if (bus.hpos == 9'd0) state_nxt = S_ROW_LOAD;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            row      <= 4'd0;
            col      <= 4'd0;
            shadow_x <= X_MIN;
            shadow_y <= Y_OFF;
            lat_x    <= X_MIN;
            lat_y    <= Y_OFF;
            vstart_q <= 1'b0;
            load_q   <= 1'b0;
            hstart_q <= 1'b0;
            pixel_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            vstart_q <= vstart_nxt;
            load_q   <= load_nxt;
            hstart_q <= hstart_nxt;
            pixel_q  <= bus.gfx & window & bus.display_on;
            active_q <= (state_nxt != S_IDLE);
            // Latch reads the pre-write shadow, so a same-cycle pos_we lands next frame.
            if (frame_start) begin
                lat_x <= shadow_x;
                lat_y <= shadow_y;
            end
            if (bus.pos_we) begin
                shadow_x <= clamp_x;
                shadow_y <= bus.sprite_y;
            end
        end
    end

    assign bus.vstart       = vstart_q;
    assign bus.load         = load_q;
    assign bus.hstart       = hstart_q;
    assign bus.sprite_pixel = pixel_q;
    assign bus.active       = active_q;
endmodule

// File: tb/tb_sprite_scheduler.sv
// Beam-scanning bench for sprite_scheduler; expected outputs are derived per beam position
// from the latched sprite rectangle, compared one cycle after each position is presented.
module tb_sprite_scheduler;
    localparam int XMIN = 4, XMAX = 240, YMAX = 224, HDISP = 256, VDISP = 240;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sprite_scheduler_if bus();
    sprite_scheduler dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [4:0] outs;
    assign outs = {bus.vstart, bus.load, bus.hstart, bus.sprite_pixel, bus.active};

    int total = 0, bad = 0;
    // reference model: shadow and frame-latched sprite rectangle
    int m_sx = XMIN, m_sy = VDISP, m_lx = XMIN, m_ly = VDISP;
    bit m_armed = 1'b0;
    bit pend_vld = 1'b0;
    logic [4:0] pend_exp;
    int pend_h, pend_v;
    int cnt_v, cnt_l, cnt_h, want_v, want_l, want_h;
    bit cnt_vld = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic int clampx(input int x);
        if (x < XMIN) return XMIN;
        if (x > XMAX) return XMAX;
        return x;
    endfunction

    task automatic check_prev();
        @(negedge clk);
        if (pend_vld) begin
            check($sformatf("outs h%0d v%0d", pend_h, pend_v), {27'd0, outs}, {27'd0, pend_exp});
            cnt_v += int'(bus.vstart);
            cnt_l += int'(bus.load);
            cnt_h += int'(bus.hstart);
        end
    endtask

    task automatic close_counts();
        if (cnt_vld) begin
            check("vstart_cnt", cnt_v, want_v);
            check("load_cnt", cnt_l, want_l);
            check("hstart_cnt", cnt_h, want_h);
        end
        cnt_v = 0; cnt_l = 0; cnt_h = 0;
    endtask

    task automatic drive(input int h, input int v, input bit we, input int wx, input int wy,
                         input bit g, input bit d, input bit rst_rel);
        bit rows, ev, el, eh, win, ep, ea;
        if (!rst_rel && reset_n) begin
            reset_n = 1'b0;
            #1 check("async_rst", {27'd0, outs}, 32'd0);
        end else if (rst_rel && !reset_n) begin
            reset_n = 1'b1;
        end
        bus.hpos = 9'(h); bus.vpos = 9'(v);
        bus.pos_we = we; bus.sprite_x = 9'(wx); bus.sprite_y = 9'(wy);
        bus.gfx = g; bus.display_on = d; bus.inloop = 1'($urandom_range(0, 1));
        if (!reset_n) begin
            m_sx = XMIN; m_sy = VDISP; m_lx = XMIN; m_ly = VDISP; m_armed = 1'b0;
        end else begin
            if (h == 0 && v == 0) begin
                m_lx = m_sx; m_ly = m_sy; m_armed = (m_sy <= YMAX);
            end
            if (we) begin
                m_sx = clampx(wx); m_sy = wy;
            end
        end
        rows = m_armed && v >= m_ly && v < m_ly + 16;
        ev   = rows && h == 0 && v == m_ly;
        el   = rows && h == 1;
        eh   = rows && h == m_lx;
        win  = rows && h > m_lx && h <= m_lx + 16;
        ep   = win && g && d;
        ea   = m_armed && (v < m_ly + 15 || (v == m_ly + 15 && h < m_lx + 16));
        pend_exp = {ev, el, eh, ep, ea};
        pend_h = h; pend_v = v; pend_vld = 1'b1;
    endtask

    // wv < 0 means: derive expected pulse counts from the latched position
    task automatic run_frame(input int ht, input int vt, input int we_v, input int we_h,
                             input int wx, input int wy, input int rst_v, input int rst_h,
                             input int cut_h, input bit gfx_one,
                             input int wv, input int wl, input int wh);
        for (int v = 0; v < vt; v++) begin
            for (int h = 0; h < ht; h++) begin
                bit g, d, rel;
                check_prev();
                if (h == 0 && v == 0) close_counts();
                rel = !(v == rst_v && h >= rst_h && h < rst_h + 3);
                g = gfx_one ? 1'b1 : 1'($urandom_range(0, 1));
                d = (h < HDISP) && (v < VDISP) && (h < cut_h);
                drive(h, v, (v == we_v && h == we_h), wx, wy, g, d, rel);
                if (h == 0 && v == 0) begin
                    if (wv < 0) begin
                        if (m_armed && m_ly + 16 <= vt) begin
                            want_v = 1; want_l = 16; want_h = 16;
                        end else begin
                            want_v = 0; want_l = 0; want_h = 0;
                        end
                    end else begin
                        want_v = wv; want_l = wl; want_h = wh;
                    end
                    cnt_vld = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bus.hpos = '0; bus.vpos = 9'd5; bus.display_on = 1'b0; bus.sprite_x = '0;
        bus.sprite_y = '0; bus.pos_we = 1'b0; bus.gfx = 1'b0; bus.inloop = 1'b0;
        #2 check("reset_outs", {27'd0, outs}, 32'd0);
        repeat (3) @(negedge clk);
        //        ht   vt  we_v we_h  wx   wy  rst_v rst_h cut  g1  counts
        run_frame( 80, 30,   5,   7,  40,  10,  -1,  0, 999, 0,  0,  0,  0);
        run_frame( 80, 30,  -1,   0,   0,   0,  -1,  0, 999, 0,  1, 16, 16);
        run_frame( 80, 30,  20,   5,  40,  10,  12, 45, 999, 0,  1,  3,  3);
        run_frame( 80, 30,  27,   3,   0,  12,  -1,  0, 999, 0,  1, 16, 16);
        run_frame( 80, 30,  29,   3, 300,   5,  -1,  0, 999, 0,  1, 16, 16);
        run_frame(260, 24,  22,   9,  50, 230,  -1,  0, 999, 0,  1, 16, 16);
        run_frame( 80, 20,  10,  10,  40,  10,  -1,  0, 999, 0,  0,  0,  0);
        run_frame(128, 30,   0,   0, 100,  10,  -1,  0, 999, 0,  1, 16, 16);
        run_frame(128, 30,  15,   3,  40, 100,  -1,  0, 999, 0,  1, 16, 16);
        run_frame( 80,120, 118,   0,  40,  10,  -1,  0, 999, 0,  1, 16, 16);
        run_frame( 80, 30,  28,   2,  20,  10,  -1,  0,  50, 1,  1, 16, 16);
        run_frame( 80, 20,  -1,   0,   0,   0,  -1,  0, 999, 0,  1, 10, 10);
        for (int i = 0; i < 4; i++) begin
            run_frame(96, 40, $urandom_range(0, 39), $urandom_range(0, 95),
                      $urandom_range(0, 70), $urandom_range(1, 20), -1, 0,
                      $urandom_range(20, 100), 0, -1, 0, 0);
        end
        check_prev();
        close_counts();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
